// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and types for the register file
package regfile_pkg;
   localparam int DATA_W = 33;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   typedef logic [DATA_W-1:0] reg_data_t;
   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W:0]   mem_data_t;
endpackage

// File: rtl/regfile_read_port.sv
// rtl/regfile_read_port.sv - combinational DEPTH:1 read mux
// Addresses beyond DEPTH read as zero.
module regfile_read_port
   import regfile_pkg::*;
(
   input  reg_data_t regs_i [DEPTH],
   input  reg_addr_t addr_i,
   output reg_data_t data_o
);

   generate
      if (DEPTH < (2 ** ADDR_W)) begin : g_partial
         always_comb begin
            data_o = '0;
            if (32'(addr_i) < DEPTH) begin
               data_o = regs_i[addr_i];
            end
         end
      end else begin : g_full
         assign data_o = regs_i[addr_i];
      end
   endgenerate

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x33 register file, one write port, four read ports
// Reads are combinational with no write-to-read bypass.
module register_file
   import regfile_pkg::*;
(
   input  logic              FAS,
   input  logic              rst_n,
   input  logic              allowWriter,
   input  logic [DATA_W-1:0] JKL,
   input  logic [ADDR_W-1:0] lowX,
   input  logic [DATA_W:0]   memRD,
   input  logic [ADDR_W-1:0] addRN,
   input  logic [ADDR_W-1:0] addRS,
   input  logic [ADDR_W-1:0] addRM,
   output logic [DATA_W-1:0] RM,
   output logic [DATA_W-1:0] RS,
   output logic [DATA_W-1:0] RN,
   output logic [DATA_W-1:0] RD,
   output logic [DATA_W-1:0] shower
);

   reg_data_t regs_q [DEPTH];
   reg_data_t shower_q;
   reg_data_t wdata_d;
   logic      addr_ok;
   logic      wr_en;

   // The top bit of memRD selects memory data over the ALU result.
   assign wdata_d = memRD[DATA_W] ? memRD[DATA_W-1:0] : JKL;

   generate
      if (DEPTH < (2 ** ADDR_W)) begin : g_range
         assign addr_ok = (32'(lowX) < DEPTH);
      end else begin : g_norange
         assign addr_ok = 1'b1;
      end
   endgenerate

   assign wr_en = allowWriter & addr_ok;

   always_ff @(posedge FAS or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= '0;
         end
         shower_q <= '0;
      end else if (wr_en) begin
         regs_q[lowX] <= wdata_d;
         shower_q     <= wdata_d;
      end
   end

   assign shower = shower_q;

   regfile_read_port u_rn (.regs_i(regs_q), .addr_i(addRN), .data_o(RN));
   regfile_read_port u_rs (.regs_i(regs_q), .addr_i(addRS), .data_o(RS));
   regfile_read_port u_rm (.regs_i(regs_q), .addr_i(addRM), .data_o(RM));
   regfile_read_port u_rd (.regs_i(regs_q), .addr_i(lowX),  .data_o(RD));

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed self-checking bench for register_file
module tb_register_file;
   import regfile_pkg::*;

   logic              FAS;
   logic              rst_n;
   logic              allowWriter;
   logic [DATA_W-1:0] JKL;
   logic [ADDR_W-1:0] lowX;
   logic [DATA_W:0]   memRD;
   logic [ADDR_W-1:0] addRN, addRS, addRM;
   logic [DATA_W-1:0] RM, RS, RN, RD, shower;

   int tests_run;
   int tests_failed;

   register_file dut (
      .FAS(FAS), .rst_n(rst_n), .allowWriter(allowWriter), .JKL(JKL),
      .lowX(lowX), .memRD(memRD), .addRN(addRN), .addRS(addRS), .addRM(addRM),
      .RM(RM), .RS(RS), .RN(RN), .RD(RD), .shower(shower)
   );

   initial FAS = 1'b0;
   always #5 FAS = ~FAS;

   task automatic test_reset();
      @(negedge FAS);
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (RN !== 33'd0) begin tests_failed++; $display("FAIL reset_RN got %0d want 0", RN); end
      tests_run++;
      if (RS !== 33'd0) begin tests_failed++; $display("FAIL reset_RS got %0d want 0", RS); end
      tests_run++;
      if (RM !== 33'd0) begin tests_failed++; $display("FAIL reset_RM got %0d want 0", RM); end
      tests_run++;
      if (RD !== 33'd0) begin tests_failed++; $display("FAIL reset_RD got %0d want 0", RD); end
      tests_run++;
      if (shower !== 33'd0) begin tests_failed++; $display("FAIL reset_shower got %0d want 0", shower); end
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_alu_write();
      @(negedge FAS);
      allowWriter = 1'b1; lowX = 5'd3; JKL = 33'd87; memRD = 34'd94;
      addRN = 5'd0; addRS = 5'd0; addRM = 5'd0;
      @(posedge FAS); #1;
      tests_run++;
      if (RD !== 33'd87) begin tests_failed++; $display("FAIL alu_RD got %0d want 87", RD); end
      tests_run++;
      if (shower !== 33'd87) begin tests_failed++; $display("FAIL alu_shower got %0d want 87", shower); end
      tests_run++;
      if (RN !== 33'd0 || RS !== 33'd0 || RM !== 33'd0) begin
         tests_failed++; $display("FAIL alu_reads got %0d/%0d/%0d want 0/0/0", RN, RS, RM);
      end
   endtask

   task automatic test_readback();
      @(negedge FAS);
      addRS = 5'd3; lowX = 5'd2; memRD = 34'd23;
      #1;
      tests_run++;
      if (RS !== 33'd87) begin tests_failed++; $display("FAIL readback_RS got %0d want 87", RS); end
      tests_run++;
      if (RD !== 33'd0) begin tests_failed++; $display("FAIL readback_RD_pre got %0d want 0", RD); end
      @(posedge FAS); #1;
      tests_run++;
      if (RD !== 33'd87) begin tests_failed++; $display("FAIL readback_RD_post got %0d want 87", RD); end
   endtask

   task automatic test_mem_write();
      @(negedge FAS);
      memRD = (34'd1 << 33) | 34'd24; lowX = 5'd6; allowWriter = 1'b1;
      @(posedge FAS); #1;
      tests_run++;
      if (shower !== 33'd24) begin tests_failed++; $display("FAIL mem_shower got %0d want 24", shower); end
      tests_run++;
      if (RD !== 33'd24) begin tests_failed++; $display("FAIL mem_RD got %0d want 24", RD); end
      addRM = 5'd6;
      #1;
      tests_run++;
      if (RM !== 33'd24) begin tests_failed++; $display("FAIL mem_RM got %0d want 24", RM); end
   endtask

   task automatic test_write_disabled();
      @(negedge FAS);
      allowWriter = 1'b0; lowX = 5'd8; memRD = (34'd1 << 33) | 34'd49;
      addRN = 5'd3; addRS = 5'd2; addRM = 5'd6;
      repeat (3) @(posedge FAS);
      #1;
      tests_run++;
      if (RD !== 33'd0) begin tests_failed++; $display("FAIL wdis_RD got %0d want 0", RD); end
      tests_run++;
      if (shower !== 33'd24) begin tests_failed++; $display("FAIL wdis_shower got %0d want 24", shower); end
      tests_run++;
      if (RN !== 33'd87 || RS !== 33'd87 || RM !== 33'd24) begin
         tests_failed++; $display("FAIL wdis_others got %0d/%0d/%0d want 87/87/24", RN, RS, RM);
      end
   endtask

   task automatic test_no_bypass();
      @(negedge FAS);
      allowWriter = 1'b1; lowX = 5'd1; JKL = 33'd63; memRD = 34'd0; addRN = 5'd1;
      #1;
      tests_run++;
      if (RN !== 33'd0) begin tests_failed++; $display("FAIL bypass_RN_pre got %0d want 0", RN); end
      @(posedge FAS); #1;
      tests_run++;
      if (RN !== 33'd63) begin tests_failed++; $display("FAIL bypass_RN_post got %0d want 63", RN); end
      tests_run++;
      if (RD !== 33'd63) begin tests_failed++; $display("FAIL bypass_RD_post got %0d want 63", RD); end
   endtask

   task automatic test_reset_override();
      @(negedge FAS);
      allowWriter = 1'b1; lowX = 5'd1; JKL = 33'd99; addRN = 5'd1; addRS = 5'd3;
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (RN !== 33'd0) begin tests_failed++; $display("FAIL ovr_RN_async got %0d want 0", RN); end
      @(posedge FAS); #1;
      tests_run++;
      if (RN !== 33'd0 || shower !== 33'd0) begin
         tests_failed++; $display("FAIL ovr_during_edge got RN=%0d shower=%0d want 0/0", RN, shower);
      end
      @(negedge FAS);
      allowWriter = 1'b0;
      rst_n = 1'b1;
      @(posedge FAS); #1;
      tests_run++;
      if (RN !== 33'd0 || RS !== 33'd0) begin
         tests_failed++; $display("FAIL ovr_after got RN=%0d RS=%0d want 0/0", RN, RS);
      end
   endtask

   initial begin
      tests_run = 0;
      tests_failed = 0;
      rst_n = 1'b1;
      allowWriter = 1'b0;
      JKL = '0; lowX = '0; memRD = '0;
      addRN = '0; addRS = '0; addRM = '0;
      test_reset();
      test_alu_write();
      test_readback();
      test_mem_write();
      test_write_disabled();
      test_no_bypass();
      test_reset_override();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
